// File: rtl/axil_pkg.sv
// AXI4-Lite response codes shared by the register file and its write-pairing helper.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_wr_pair.sv
// AW/W pairing for an AXI4-Lite slave. Address and data beats may arrive in
// either order or together. A beat that fires on the commit edge goes straight
// into that commit, so a same-cycle AW+W pair produces B on the next cycle.
module axi_lite_wr_pair #(
  parameter int ADDR_WD = 8,
  parameter int DATA_WD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               awvalid_i,
  input  logic [ADDR_WD-1:0] awaddr_i,
  output logic               awready_o,
  input  logic               wvalid_i,
  input  logic [DATA_WD-1:0] wdata_i,
  output logic               wready_o,
  input  logic               b_free_i,
  output logic               commit_o,
  output logic [ADDR_WD-1:0] cm_addr_o,
  output logic [DATA_WD-1:0] cm_data_o
);

  logic               aw_have_q, aw_have_d;
  logic               w_have_q, w_have_d;
  logic [ADDR_WD-1:0] aw_addr_q;
  logic [DATA_WD-1:0] w_data_q;
  logic               aw_fire, w_fire, aw_eff, w_eff;

  assign awready_o = !aw_have_q;
  assign wready_o  = !w_have_q;
  assign aw_fire   = awvalid_i && awready_o;
  assign w_fire    = wvalid_i && wready_o;
  assign aw_eff    = aw_have_q || aw_fire;
  assign w_eff     = w_have_q || w_fire;
  assign commit_o  = aw_eff && w_eff && b_free_i;
  assign cm_addr_o = aw_have_q ? aw_addr_q : awaddr_i;
  assign cm_data_o = w_have_q ? w_data_q : wdata_i;

  // Next-state of the holding flags: a commit consumes both beats, otherwise a held or newly fired beat stays held.
  always_comb begin
    aw_have_d = aw_eff;
    w_have_d  = w_eff;
    if (commit_o) begin
      aw_have_d = 1'b0;
      w_have_d  = 1'b0;
    end
  end

  // Holding flags; reset discards any half-captured write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
    end else begin
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
    end
  end

  // Payload latches; only meaningful while the matching flag is set, so no reset is needed.
  always_ff @(posedge clk) begin
    if (aw_fire) aw_addr_q <= awaddr_i;
    if (w_fire)  w_data_q  <= wdata_i;
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register bank: NUM_REGS registers, one per address.
// Out-of-range accesses get DECERR (writes dropped, reads return 0).
// Optional feature macro AXIL_REGFILE_CNT_EN: read-only counter of completed
// B handshakes at address NUM_REGS (writes to it return SLVERR and are dropped).
module axi_lite_regfile
  import axil_pkg::*;
#(
  parameter int                 ADDR_WD   = 8,
  parameter int                 DATA_WD   = 8,
  parameter int                 NUM_REGS  = 16,
  parameter logic [DATA_WD-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               awvalid,
  input  logic [ADDR_WD-1:0] awaddr,
  output logic               awready,
  input  logic               wvalid,
  input  logic [DATA_WD-1:0] wdata,
  output logic               wready,
  output logic               bvalid,
  output logic [1:0]         bresp,
  input  logic               bready,
  input  logic               arvalid,
  input  logic [ADDR_WD-1:0] araddr,
  output logic               arready,
  output logic               rvalid,
  output logic [DATA_WD-1:0] rdata,
  output logic [1:0]         rresp,
  input  logic               rready
);

  logic [DATA_WD-1:0] regs_q [NUM_REGS];
  logic               bvalid_q, rvalid_q;
  logic [1:0]         bresp_q, rresp_q;
  logic [DATA_WD-1:0] rdata_q;
  logic               commit, b_free, ar_fire;
  logic [ADDR_WD-1:0] cm_addr;
  logic [DATA_WD-1:0] cm_data;
  logic [1:0]         wr_resp_d, rd_resp_d;
  logic [DATA_WD-1:0] rd_data_d;
`ifdef AXIL_REGFILE_CNT_EN
  logic [DATA_WD-1:0] cnt_q;
`endif

  function automatic logic in_range(input logic [ADDR_WD-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  function automatic logic is_cnt_addr(input logic [ADDR_WD-1:0] a);
    return 32'(a) == NUM_REGS;
  endfunction

  assign b_free  = !bvalid_q || bready;
  assign arready = !rvalid_q || rready;
  assign ar_fire = arvalid && arready;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  axi_lite_wr_pair #(
    .ADDR_WD (ADDR_WD),
    .DATA_WD (DATA_WD)
  ) u_wr_pair (
    .clk       (clk),
    .rst_n     (rst_n),
    .awvalid_i (awvalid),
    .awaddr_i  (awaddr),
    .awready_o (awready),
    .wvalid_i  (wvalid),
    .wdata_i   (wdata),
    .wready_o  (wready),
    .b_free_i  (b_free),
    .commit_o  (commit),
    .cm_addr_o (cm_addr),
    .cm_data_o (cm_data)
  );

  // Write response code for the pair being committed.
  always_comb begin
    wr_resp_d = RESP_DECERR;
    if (in_range(cm_addr)) wr_resp_d = RESP_OKAY;
`ifdef AXIL_REGFILE_CNT_EN
    else if (is_cnt_addr(cm_addr)) wr_resp_d = RESP_SLVERR;
`endif
  end

  // Read decode: unmatched addresses fall through to DECERR with zero data.
  always_comb begin
    rd_data_d = '0;
    rd_resp_d = RESP_DECERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (araddr == ADDR_WD'(i)) begin
        rd_data_d = regs_q[i];
        rd_resp_d = RESP_OKAY;
      end
    end
`ifdef AXIL_REGFILE_CNT_EN
    if (is_cnt_addr(araddr)) begin
      rd_data_d = cnt_q;
      rd_resp_d = RESP_OKAY;
    end
`endif
  end

  // Register array; updated only by an in-range commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (commit && in_range(cm_addr)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cm_addr == ADDR_WD'(i)) regs_q[i] <= cm_data;
      end
    end
  end

  // B channel: a commit loads a fresh response, a handshake without commit retires it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_resp_d;
    end else if (bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // R channel: an AR fire loads a beat, an R handshake alone drops valid and keeps data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data_d;
      rresp_q  <= rd_resp_d;
    end else if (rready) begin
      rvalid_q <= 1'b0;
    end
  end

`ifdef AXIL_REGFILE_CNT_EN
  // Completed-write counter; wraps naturally at DATA_WD bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (bvalid_q && bready) cnt_q <= cnt_q + 1'b1;
  end
`endif

endmodule
